// File: rtl/coproc_scheduler.sv
// Two-channel round-robin sequencer for the shared adder/multiplier datapath.
// Each accepted operand x produces ((x*x) + ADD_CONST)^2 mod 256, tagged with its requester id.
module coproc_scheduler #(
    parameter logic [7:0] ADD_CONST = 8'd3
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    output logic       o_req1_ready,
    output logic       o_resp_valid,
    output logic       o_resp_id,
    output logic [7:0] o_resp_data,
    input  logic       i_resp_ready,
    output logic [7:0] o_mul_a,
    output logic [7:0] o_mul_b,
    input  logic [7:0] i_mul_result,
    output logic [7:0] o_add_a,
    output logic [7:0] o_add_b,
    input  logic [7:0] i_add_result,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL1 = 3'd1,
        ST_ADD  = 3'd2,
        ST_MUL2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_rr_last;
    logic       r_owner;
    logic [7:0] r_mul;
    logic [7:0] r_add;

    logic       w_grant_valid;
    logic       w_grant_id;

    // Reset suppresses any grant so a request arriving with reset is never acknowledged.
    assign w_grant_valid = ~i_reset & (i_req0_valid | i_req1_valid);
    assign w_grant_id    = (i_req0_valid & i_req1_valid) ? ~r_rr_last : i_req1_valid;

    // State register and datapath capture registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_mul     <= 8'd0;
            r_add     <= 8'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_mul   <= i_mul_result;
                        r_owner <= w_grant_id;
                    end
                end
                ST_ADD: begin
                    r_add <= i_add_result;
                end
                ST_MUL2: begin
                    r_mul <= i_mul_result;
                end
                ST_DONE: begin
                    if (i_resp_ready) begin
                        r_rr_last <= r_owner;
                    end
                end
                default: begin
                    r_mul <= r_mul;
                end
            endcase
        end
    end

    // Next-state decode and per-state datapath/handshake outputs; unused operands stay at zero.
    always_comb begin
        w_next_state = ST_IDLE;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_resp_valid = 1'b0;
        o_resp_id    = 1'b0;
        o_resp_data  = 8'd0;
        o_mul_a      = 8'd0;
        o_mul_b      = 8'd0;
        o_add_a      = 8'd0;
        o_add_b      = 8'd0;
        o_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_grant_valid) begin
                    w_next_state = ST_MUL1;
                    if (w_grant_id) begin
                        o_req1_ready = 1'b1;
                        o_mul_a      = i_req1_data;
                        o_mul_b      = i_req1_data;
                    end else begin
                        o_req0_ready = 1'b1;
                        o_mul_a      = i_req0_data;
                        o_mul_b      = i_req0_data;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_MUL1: begin
                w_next_state = ST_ADD;
            end
            ST_ADD: begin
                w_next_state = ST_MUL2;
                o_add_a      = r_mul;
                o_add_b      = ADD_CONST;
            end
            ST_MUL2: begin
                w_next_state = ST_DONE;
                o_mul_a      = r_add;
                o_mul_b      = r_add;
            end
            ST_DONE: begin
                o_resp_valid = 1'b1;
                o_resp_id    = r_owner;
                o_resp_data  = r_mul;
                if (i_resp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_coproc_scheduler.sv
// Self-checking bench for coproc_scheduler: external adder/multiplier models plus a
// job-level reference (result formula, round-robin pointer, fixed latency).
module tb_coproc_scheduler;

    localparam logic [7:0] C = 8'd3;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_req0_valid, i_req1_valid;
    logic [7:0] i_req0_data, i_req1_data;
    logic       o_req0_ready, o_req1_ready;
    logic       o_resp_valid, o_resp_id;
    logic [7:0] o_resp_data;
    logic       i_resp_ready;
    logic [7:0] o_mul_a, o_mul_b, o_add_a, o_add_b;
    logic [7:0] w_mul_result, w_add_result;
    logic       o_busy;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic m_last       = 1'b1;

    always #5 clk = ~clk;

    assign w_mul_result = 8'(o_mul_a * o_mul_b);
    assign w_add_result = 8'(o_add_a + o_add_b);

    coproc_scheduler #(.ADD_CONST(C)) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_req0_valid (i_req0_valid),
        .i_req0_data  (i_req0_data),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_data  (i_req1_data),
        .o_req1_ready (o_req1_ready),
        .o_resp_valid (o_resp_valid),
        .o_resp_id    (o_resp_id),
        .o_resp_data  (o_resp_data),
        .i_resp_ready (i_resp_ready),
        .o_mul_a      (o_mul_a),
        .o_mul_b      (o_mul_b),
        .i_mul_result (w_mul_result),
        .o_add_a      (o_add_a),
        .o_add_b      (o_add_b),
        .i_add_result (w_add_result),
        .o_busy       (o_busy)
    );

    function automatic int sq_mod(input int v);
        return (v * v) % 256;
    endfunction

    function automatic logic [7:0] ref_result(input logic [7:0] x);
        int mid;
        mid = (sq_mod(int'(x)) + int'(C)) % 256;
        return 8'(sq_mod(mid));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete job starting in an IDLE cycle; keep holds the request valids through the job.
    task automatic run_job(input logic v0, input logic [7:0] d0, input logic v1,
                           input logic [7:0] d1, input int stall, input logic keep);
        logic       exp_id;
        logic [7:0] x, exp_res, sq, mid;
        exp_id  = (v0 && v1) ? ~m_last : v1;
        x       = exp_id ? d1 : d0;
        exp_res = ref_result(x);
        sq      = 8'(sq_mod(int'(x)));
        mid     = 8'((int'(sq) + int'(C)) % 256);
        i_req0_valid = v0; i_req0_data = d0;
        i_req1_valid = v1; i_req1_data = d1;
        i_resp_ready = 1'b0;
        #1;
        tests_run++;
        if (o_req0_ready !== (v0 && !exp_id) || o_req1_ready !== (v1 && exp_id)) begin
            tests_failed++;
            $display("FAIL grant: ready0=%0b ready1=%0b, expected %0b %0b", o_req0_ready,
                     o_req1_ready, (v0 && !exp_id), (v1 && exp_id));
        end
        tests_run++;
        if (o_mul_a !== x || o_mul_b !== x || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_operands: mul_a=%0d mul_b=%0d busy=%0b, expected %0d %0d 0",
                     o_mul_a, o_mul_b, o_busy, x, x);
        end
        tick();
        if (!keep) begin
            i_req0_valid = 1'b0;
            i_req1_valid = 1'b0;
        end
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests_run++;
            if (o_busy !== 1'b1 || o_resp_valid !== 1'b0 || o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL pipeline_c%0d: busy=%0b resp_valid=%0b ready=%0b%0b, expected 1 0 00",
                         c, o_busy, o_resp_valid, o_req0_ready, o_req1_ready);
            end
            if (c == 2) begin
                tests_run++;
                if (o_add_a !== sq || o_add_b !== C || o_mul_a !== 8'd0 || o_mul_b !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL add_step: add_a=%0d add_b=%0d mul=%0d/%0d, expected %0d %0d 0/0",
                             o_add_a, o_add_b, o_mul_a, o_mul_b, sq, C);
                end
            end
            if (c == 3) begin
                tests_run++;
                if (o_mul_a !== mid || o_mul_b !== mid || o_add_a !== 8'd0 || o_add_b !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL mul2_step: mul=%0d/%0d add=%0d/%0d, expected %0d/%0d 0/0",
                             o_mul_a, o_mul_b, o_add_a, o_add_b, mid, mid);
                end
            end
            tick();
        end
        for (int s = 0; s <= stall; s++) begin
            #1;
            tests_run++;
            if (o_resp_valid !== 1'b1 || o_resp_data !== exp_res || o_resp_id !== exp_id ||
                o_busy !== 1'b1 || o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL response(x=%0d,hold %0d): valid=%0b data=%0d id=%0b busy=%0b ready=%0b%0b, expected 1 %0d %0b 1 00",
                         x, s, o_resp_valid, o_resp_data, o_resp_id, o_busy, o_req0_ready,
                         o_req1_ready, exp_res, exp_id);
            end
            if (s < stall) tick();
        end
        i_resp_ready = 1'b1;
        tick();
        #1;
        i_resp_ready = 1'b0;
        m_last = exp_id;
        tests_run++;
        if (o_busy !== 1'b0 || o_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL return_idle: busy=%0b resp_valid=%0b, expected 0 0", o_busy, o_resp_valid);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_req0_valid = 1'b1; i_req0_data = 8'd9;
        i_req1_valid = 1'b1; i_req1_data = 8'd4;
        tick();
        tick();
        #1;
        tests_run++;
        if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: ready=%0b%0b, expected 00", o_req0_ready, o_req1_ready);
        end
        tests_run++;
        if (o_resp_valid !== 1'b0 || o_resp_id !== 1'b0 || o_resp_data !== 8'd0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_resp: valid=%0b id=%0b data=%0d busy=%0b, expected 0 0 0 0",
                     o_resp_valid, o_resp_id, o_resp_data, o_busy);
        end
        tests_run++;
        if (o_mul_a !== 8'd0 || o_mul_b !== 8'd0 || o_add_a !== 8'd0 || o_add_b !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_operands: %0d %0d %0d %0d, expected all 0", o_mul_a, o_mul_b,
                     o_add_a, o_add_b);
        end
        i_reset = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        m_last = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            tests_run++;
            if (o_mul_a !== 8'd0 || o_mul_b !== 8'd0 || o_add_a !== 8'd0 || o_add_b !== 8'd0 ||
                o_busy !== 1'b0 || o_resp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_c%0d: ops=%0d %0d %0d %0d busy=%0b resp_valid=%0b, expected all 0",
                         i, o_mul_a, o_mul_b, o_add_a, o_add_b, o_busy, o_resp_valid);
            end
        end
    endtask

    task automatic test_single();
        run_job(1'b1, 8'd2, 1'b0, 8'd0, 0, 1'b0);
    endtask

    task automatic test_contention();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        m_last = 1'b1;
        for (int j = 0; j < 4; j++) run_job(1'b1, 8'd7, 1'b1, 8'd16, 0, 1'b1);
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
    endtask

    task automatic test_wrap();
        run_job(1'b1, 8'd255, 1'b0, 8'd0, 0, 1'b0);
        run_job(1'b0, 8'd0, 1'b1, 8'd0, 0, 1'b0);
        run_job(1'b1, 8'd5, 1'b0, 8'd0, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_job(1'b1, 8'd11, 1'b1, 8'd200, 6, 1'b1);
        run_job(m_last ? 1'b1 : 1'b0, 8'd11, m_last ? 1'b0 : 1'b1, 8'd200, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        i_req0_valid = 1'b1; i_req0_data = 8'd6;
        i_req1_valid = 1'b0;
        #1;
        tests_run++;
        if (o_req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_accept: ready0=%0b, expected 1", o_req0_ready);
        end
        tick();
        i_req0_valid = 1'b0;
        tick();
        #1;
        tests_run++;
        if (o_add_a !== 8'd36) begin
            tests_failed++;
            $display("FAIL midreset_in_add: add_a=%0d, expected 36", o_add_a);
        end
        i_reset = 1'b1;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        i_req0_data = 8'd1;  i_req1_data = 8'd2;
        tick();
        #1;
        tests_run++;
        if (o_busy !== 1'b0 || o_resp_valid !== 1'b0 || o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0 ||
            o_add_a !== 8'd0 || o_mul_a !== 8'd0 || o_resp_data !== 8'd0) begin
            tests_failed++;
            $display("FAIL midreset_abort: busy=%0b valid=%0b ready=%0b%0b add_a=%0d mul_a=%0d data=%0d, expected all 0",
                     o_busy, o_resp_valid, o_req0_ready, o_req1_ready, o_add_a, o_mul_a, o_resp_data);
        end
        i_reset = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        m_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            tests_run++;
            if (o_resp_valid !== 1'b0 || o_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_quiet_c%0d: resp_valid=%0b busy=%0b, expected 0 0", i,
                         o_resp_valid, o_busy);
            end
        end
        run_job(1'b1, 8'd21, 1'b1, 8'd99, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            int         pat;
            logic [7:0] a, b;
            pat = int'($urandom_range(1, 3));
            a   = 8'($urandom);
            b   = 8'($urandom);
            run_job(pat[0], a, pat[1], b, int'($urandom_range(0, 3)), 1'($urandom));
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_req0_valid = 1'b0; i_req0_data = 8'd0;
        i_req1_valid = 1'b0; i_req1_data = 8'd0;
        i_resp_ready = 1'b0;
        test_reset();
        test_idle();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/coproc_scheduler.md
# coproc_scheduler

Sequencer and two-channel arbiter for the shared 8-bit coprocessor datapath, which has one combinational adder and one combinational multiplier. It accepts 8-bit operands from two requesters over valid/ready handshakes and arbitrates between them round-robin. For each accepted operand it drives the external adder/multiplier through a fixed three-step program, result = ((x·x) + ADD_CONST)², all arithmetic mod 2^8. The result is returned on a single response channel tagged with the requester id. The block sits between the host port interface logic and the adder/multiplier datapath, replacing per-client hard-wired sequencing.

## Interface
- ADD_CONST, default 3: constant added in the second program step, 8 bits.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand.
- req0_data  in  8  requester 0 operand x; held stable while req0_valid is high and req0_ready is low.
- req0_ready  out  1  requester 0 operand accepted this cycle.
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_id  out  1  requester that owns the result.
- resp_data  out  8  result.
- resp_ready  in  1  consumer takes the result.
- mul_a, mul_b  out  8 each  multiplier operands.
- mul_result  in  8  low 8 bits of mul_a·mul_b, combinational.
- add_a, add_b  out  8 each  adder operands.
- add_result  in  8  (add_a+add_b) mod 256, combinational.
- busy  out  1  high in every state except IDLE.

## Operation
- **States:**
  - IDLE → MUL1 → ADD → MUL2 → DONE → IDLE.
  - The state register is 3 bits; unused encodings go to IDLE.
- **IDLE:**
  - If no request is valid, stay in IDLE.
  - If exactly one request is valid, grant it.
  - If both are valid, grant the channel not equal to rr_last.
  - In the grant cycle: assert the granted reqN_ready (combinational), drive mul_a=mul_b=reqN_data, register r_mul<=mul_result, set owner<=N, go to MUL1.
  - MUL1 is a one-cycle bookkeeping state: next cycle goes to ADD, no datapath use.
- **ADD:** drive add_a=r_mul, add_b=ADD_CONST; register r_add<=add_result; go to MUL2.
- **MUL2:** drive mul_a=mul_b=r_add; register r_mul<=mul_result; go to DONE.
- **DONE:**
  - resp_valid=1, resp_data=r_mul, resp_id=owner.
  - On resp_ready=1: rr_last<=owner, go to IDLE.
  - Otherwise hold; outputs stay stable.
- **Idle operands:** any datapath operand not used in the current state is driven to 0.
- **Ready:** reqN_ready is never asserted outside IDLE, and never to both channels in the same cycle.
- **Arithmetic:** all values are 8-bit, wrap mod 256, with no overflow flag.

## Timing
- **Reset values:**
  - state=IDLE, rr_last=1 (channel 0 wins the first contention), owner=0, r_mul=0, r_add=0.
  - Outputs: resp_valid=0, resp_id=0, resp_data=0, busy=0, req*_ready=0, all operands=0.
- **Latency:** accept at cycle T (valid&ready) → states MUL1 at T+1, ADD at T+2, MUL2 at T+3 → resp_valid first high at T+4.
- **Throughput:** resp_ready held high → DONE lasts one cycle → back in IDLE at T+5, next accept possible at T+5, i.e. one result per 5 cycles.
- **Backpressure:** resp_ready low stalls in DONE indefinitely; no new operand is accepted; busy stays 1.
- **Request drop:** a request deasserted before being granted is simply not taken; no state change.
- **Reset mid-operation:** reset in any state aborts the job in the next cycle. The pending result is discarded, no resp_valid is generated, and the arbitration pointer returns to rr_last=1.
- **Simultaneous reset and request:** reset wins; no ready is asserted.

## Test plan
- **Single request:** reset, then req0 x=2 → req0_ready at T, resp_valid at T+4 with resp_data=49 (4+3=7, 7²), resp_id=0, busy high T+1..T+4.
- **Contention:** both valid from reset, req0 x=7, req1 x=16 → first result 144, id 0; second result 9, id 1. Holding both valid for 4 jobs → ids alternate 0,1,0,1.
- **Wrap-around:** x=255 → 16 (255²≡1, +3=4, 4²); x=0 → 9; x=5 → 16 (28²=784≡16).
- **Response backpressure:** resp_ready low for 6 cycles in DONE → resp_valid, resp_data, resp_id stable; req0_ready and req1_ready stay 0 while a new request waits. Raising resp_ready → IDLE next cycle, then the waiting request is accepted.
- **Reset mid-job:** reset asserted while in ADD → no resp_valid afterwards; all outputs at reset values; a later simultaneous request grants channel 0 first.
- **Datapath idle:** no requests for 10 cycles → mul_a, mul_b, add_a, add_b all 0; busy=0.
